// File: rtl/pled_pkg.sv
// Shared state type, parameter defaults and square-law gamma helper for the
// Pmod_PLED2 PWM driver.
package pled_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    OFF,
    RAMP,
    RUN
  } pled_state_e;

  localparam int unsigned PLED_PWM_W        = 8;
  localparam int unsigned PLED_PRESCALE     = 39;
  localparam int unsigned PLED_RAMP_PERIODS = 4;
  localparam int unsigned PLED_LOCK_WAIT    = 1024;
  localparam int unsigned PLED_GAMMA_MAX_W  = 16;

  // (duty*duty) >> width; a lit LED never collapses to zero effective duty.
  function automatic logic [PLED_GAMMA_MAX_W-1:0] f_gamma(
    input logic [PLED_GAMMA_MAX_W-1:0] duty,
    input int unsigned                 width
  );
    logic [2*PLED_GAMMA_MAX_W-1:0] sq;
    sq = ({{PLED_GAMMA_MAX_W{1'b0}}, duty} * {{PLED_GAMMA_MAX_W{1'b0}}, duty}) >> width;
    if (duty != '0 && sq == '0) begin
      return {{(PLED_GAMMA_MAX_W-1){1'b0}}, 1'b1};
    end
    return sq[PLED_GAMMA_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pled_pwm_core.sv
// PWM timebase (prescaler + phase counter) and registered duty comparator.
// PLED_GAMMA_EN adds one pipeline stage to the compare (pwm_out latency 2).
module pled_pwm_core
  import pled_pkg::*;
#(
  parameter int unsigned PWM_W    = PLED_PWM_W,
  parameter int unsigned PRESCALE = PLED_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PWM_W-1:0] duty_eff,
  output logic             pwm_out,
  output logic             pend
);

  localparam int unsigned PSW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PSW-1:0]   presc;
  logic [PWM_W-1:0] phase;
  logic             tick;
  logic             hit;

  assign tick = run && (presc == PSW'(PRESCALE));
  assign pend = tick && (phase == '1);
  assign hit  = run && (phase < duty_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      phase <= '0;
    end else if (!run) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        phase <= phase + 1'b1;
      end
    end
  end

`ifdef PLED_GAMMA_EN
  logic hit_q;

  // run gates both stages so a lock loss still darkens the LED on its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      hit_q   <= hit;
      pwm_out <= run && hit_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= hit;
    end
  end
`endif

endmodule

// File: rtl/pled_pwm_driver.sv
// Power-LED PWM driver: lock qualifier, WAIT_LOCK/OFF/RAMP/RUN FSM and soft ramp.
// Optional square-law duty curve enabled by defining PLED_GAMMA_EN.
module pled_pwm_driver
  import pled_pkg::*;
#(
  parameter int unsigned PWM_W        = PLED_PWM_W,
  parameter int unsigned PRESCALE     = PLED_PRESCALE,
  parameter int unsigned RAMP_PERIODS = PLED_RAMP_PERIODS,
  parameter int unsigned LOCK_WAIT    = PLED_LOCK_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             enable,
  input  logic             duty_load,
  input  logic [PWM_W-1:0] duty_in,
  output logic             pwm_out,
  output logic [PWM_W-1:0] duty_now,
  output logic             busy,
  output logic             ready
);

  localparam int unsigned LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int unsigned RCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  pled_state_e      state, state_nxt;
  logic             lock_m, lock_s;
  logic [LCW-1:0]   lock_cnt;
  logic [RCW-1:0]   ramp_cnt;
  logic [PWM_W-1:0] target;
  logic [PWM_W-1:0] eff_tgt;
  logic [PWM_W-1:0] duty_eff;
  logic             lock_lost;
  logic             lock_done;
  logic             run;
  logic             pend;
  logic             step;

  assign eff_tgt   = enable ? target : '0;
  assign lock_lost = (state != WAIT_LOCK) && !lock_s;
  assign lock_done = lock_s && (lock_cnt == LCW'(LOCK_WAIT - 1));
  // Including lock_s here makes the core clear its counters and pwm_out on the lock-loss edge.
  assign run       = ((state == RAMP) || (state == RUN)) && lock_s;
  assign step      = (state == RAMP) && pend && (ramp_cnt == RCW'(RAMP_PERIODS - 1))
                     && (duty_now != eff_tgt);
  assign busy      = (state == RAMP);
  assign ready     = (state != WAIT_LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nxt = state;
    if (lock_lost) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: if (lock_done) state_nxt = OFF;
        OFF:       if (eff_tgt != '0) state_nxt = RAMP;
        RAMP:      if (duty_now == eff_tgt) state_nxt = (eff_tgt != '0) ? RUN : OFF;
        RUN:       if (eff_tgt != duty_now) state_nxt = RAMP;
        default:   state_nxt = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      target   <= '0;
      duty_now <= '0;
      lock_cnt <= '0;
      ramp_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (duty_load) begin
        target <= duty_in;
      end
      if ((state != WAIT_LOCK) || !lock_s || lock_done) begin
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      if (lock_lost) begin
        duty_now <= '0;
      end else if (step) begin
        duty_now <= (eff_tgt > duty_now) ? duty_now + 1'b1 : duty_now - 1'b1;
      end
      if (state != RAMP) begin
        ramp_cnt <= '0;
      end else if (pend) begin
        ramp_cnt <= (ramp_cnt == RCW'(RAMP_PERIODS - 1)) ? '0 : ramp_cnt + 1'b1;
      end
    end
  end

`ifdef PLED_GAMMA_EN
  logic [PLED_GAMMA_MAX_W-1:0] gamma_full;
  assign gamma_full = f_gamma(PLED_GAMMA_MAX_W'(duty_now), PWM_W);
  assign duty_eff   = PWM_W'(gamma_full);
`else
  assign duty_eff = duty_now;
`endif

  pled_pwm_core #(
    .PWM_W   (PWM_W),
    .PRESCALE(PRESCALE)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .duty_eff(duty_eff),
    .pwm_out (pwm_out),
    .pend    (pend)
  );

endmodule

// File: tb/tb_pled_pwm_driver.sv
// Scoreboard bench for pled_pwm_driver (PWM_W=4, PRESCALE=0, RAMP_PERIODS=1, LOCK_WAIT=4).
// Expected duty_now steps are queued by the stimulus and popped by a monitor on each change.
module tb_pled_pwm_driver;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pll_lock;
  logic         enable;
  logic         duty_load;
  logic [W-1:0] duty_in;
  logic         pwm_out;
  logic [W-1:0] duty_now;
  logic         busy;
  logic         ready;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit mon_on   = 1'b0;

  always #5 clk = ~clk;

  pled_pwm_driver #(
    .PWM_W       (W),
    .PRESCALE    (0),
    .RAMP_PERIODS(1),
    .LOCK_WAIT   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .enable   (enable),
    .duty_load(duty_load),
    .duty_in  (duty_in),
    .pwm_out  (pwm_out),
    .duty_now (duty_now),
    .busy     (busy),
    .ready    (ready)
  );

`ifdef PLED_GAMMA_EN
  localparam int LAT = 2;
  function automatic int hi_cnt(input int d);
    int p;
    p = (d * d) >> W;
    if (d != 0 && p == 0) p = 1;
    return p;
  endfunction
`else
  localparam int LAT = 1;
  function automatic int hi_cnt(input int d);
    return d;
  endfunction
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int from, input int to);
    int v;
    v = from;
    while (v != to) begin
      v += (to > v) ? 1 : -1;
      exp_q.push_back(v);
    end
  endtask

  task automatic load(input int v);
    duty_in   = W'(v);
    duty_load = 1'b1;
    cyc(1);
    duty_load = 1'b0;
  endtask

  task automatic wait_duty(input int v);
    for (int i = 0; i < 400 && int'(duty_now) != v; i++) cyc(1);
    chk("wait_duty", int'(duty_now), v);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600 && busy; i++) cyc(1);
    chk(name, int'(busy), 0);
  endtask

  task automatic check_high(input string name, input int d);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      c += int'(pwm_out);
    end
    chk(name, c, hi_cnt(d));
  endtask

  initial begin : monitor
    logic [W-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_on && duty_now != prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL duty_step: got %0d, expected no change from %0d", duty_now, prev);
        end else begin
          chk("duty_step", int'(duty_now), exp_q.pop_front());
        end
      end
      prev = duty_now;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; enable = 1'b0; duty_load = 1'b0; duty_in = '0;
    cyc(3);
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_duty", int'(duty_now), 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // 1: lock qualification with a one-cycle dropout
    pll_lock = 1'b1; cyc(2);
    pll_lock = 1'b0; cyc(1);
    pll_lock = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      chk("lock_qualify", int'(ready), 0);
    end
    cyc(1);
    chk("lock_ready", int'(ready), 1);
    chk("lock_busy", int'(busy), 0);
    chk("lock_pwm", int'(pwm_out), 0);

    // 2: ramp 0 -> 5, output latency, RUN high count
    enable = 1'b1;
    push_seq(0, 5);
    load(5);
    cyc(1);
    chk("t2_busy", int'(busy), 1);
    wait_duty(1);
    chk("lat_0", int'(pwm_out), 0);
    cyc(1); chk("lat_1", int'(pwm_out), (LAT == 1) ? 1 : 0);
    cyc(1); chk("lat_2", int'(pwm_out), (LAT == 2) ? 1 : 0);
    wait_idle("t2_idle");
    check_high("t2_high5", 5);

    // 3: ramp down, up, then retarget exactly on a pend edge
    push_seq(5, 2);
    load(2); cyc(1); chk("t3a_busy", int'(busy), 1);
    wait_idle("t3a_idle");
    push_seq(2, 6);
    load(6); cyc(1); chk("t3b_busy", int'(busy), 1);
    wait_idle("t3b_idle");
    push_seq(6, 3);
    push_seq(3, 9);
    load(1); cyc(1); chk("t3c_busy", int'(busy), 1);
    wait_duty(4);
    cyc(15);
    load(9);
    wait_idle("t3c_idle");
    check_high("t3_high9", 9);

    // 4: enable drop ramps to OFF, re-enable returns to kept target
    push_seq(9, 3);
    load(3); cyc(1); chk("t4_busy", int'(busy), 1);
    wait_idle("t4_run3");
    push_seq(3, 0);
    enable = 1'b0;
    cyc(1); chk("t4_down_busy", int'(busy), 1);
    wait_idle("t4_off");
    chk("t4_ready", int'(ready), 1);
    check_high("t4_dark", 0);
    push_seq(0, 3);
    enable = 1'b1;
    cyc(1); chk("t4_up_busy", int'(busy), 1);
    wait_idle("t4_rerun");

    // 5: lock loss mid-ramp, then relock re-ramps to kept target
    push_seq(3, 5);
    exp_q.push_back(0);
    load(8); cyc(1); chk("t5_busy", int'(busy), 1);
    wait_duty(5);
    pll_lock = 1'b0;
    cyc(2);
    chk("t5_pre_ready", int'(ready), 1);
    chk("t5_pre_duty", int'(duty_now), 5);
    cyc(1);
    chk("t5_pwm", int'(pwm_out), 0);
    chk("t5_duty", int'(duty_now), 0);
    chk("t5_ready", int'(ready), 0);
    chk("t5_busy_off", int'(busy), 0);
    push_seq(0, 8);
    pll_lock = 1'b1;
    cyc(5); chk("t5_relock_wait", int'(ready), 0);
    cyc(1); chk("t5_relock", int'(ready), 1);
    cyc(1); chk("t5_reramp_busy", int'(busy), 1);
    wait_idle("t5_reramp");
    check_high("t5_high8", 8);

    // 6: full-scale duty
    push_seq(8, 15);
    load(15); cyc(1); chk("t6_busy", int'(busy), 1);
    wait_idle("t6_idle");
    check_high("t6_high15", 15);

    cyc(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
